// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial pattern link: transmitter state type and
// the default sync framing that the detector side also matches against.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  localparam int SYNC_W_DEFAULT = 4;
  localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PATTERN_DEFAULT = 4'b1011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register, MSB first; one-cycle load, shifts only on i_shift.
// o_next_msb exposes the bit that becomes MSB after the next shift.
module piso_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_dat,
  input  logic              i_shift,
  output logic              o_msb,
  output logic              o_next_msb
);

  logic [DATA_W-1:0] r_shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_load_dat;
    end else if (i_shift) begin
      r_shreg <= r_shreg << 1;
    end
  end

  assign o_msb = r_shreg[DATA_W-1];

  generate
    if (DATA_W > 1) begin : g_next
      assign o_next_msb = r_shreg[DATA_W-2];
    end else begin : g_next_single
      assign o_next_msb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sync_pattern_transmitter.sv
// Frames each accepted word as sync pattern + MSB-first payload + idle gap on one serial line.
// Accepts only in IDLE (data_ready registered); every bit advances solely on bit_en.
module sync_pattern_transmitter
  import serial_link_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int                GAP_BITS     = 2,
  parameter logic              IDLE_LEVEL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              frame_active,
  output logic              done
);

  localparam int MAX_CNT = max3(SYNC_W, DATA_W, GAP_BITS);
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  tx_state_t        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_serial, w_serial;
  logic             r_ready, w_ready;
  logic             r_active, w_active;
  logic             r_done, w_done;

  logic w_accept;
  logic w_shift;
  logic w_sync_bit;
  logic w_piso_msb;
  logic w_piso_next;

  assign w_accept = data_valid && r_ready;
  assign w_shift  = (r_state == DATA) && bit_en && (r_cnt != '0);
  // Pattern bit that follows the one currently on the line (only used while r_cnt > 0).
  assign w_sync_bit = |(SYNC_PATTERN & (SYNC_W'(1) << (r_cnt - CNT_W'(1))));

  piso_shift_reg #(
    .DATA_W(DATA_W)
  ) u_piso (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_accept),
    .i_load_dat (data_in),
    .i_shift    (w_shift),
    .o_msb      (w_piso_msb),
    .o_next_msb (w_piso_next)
  );

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_serial = r_serial;
    w_ready  = r_ready;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_state  = SYNC;
          w_cnt    = CNT_W'(SYNC_W - 1);
          w_serial = SYNC_PATTERN[SYNC_W-1];
          w_ready  = 1'b0;
        end
      end
      SYNC: begin
        if (bit_en) begin
          if (r_cnt != '0) begin
            w_cnt    = r_cnt - CNT_W'(1);
            w_serial = w_sync_bit;
          end else begin
            w_state  = DATA;
            w_cnt    = CNT_W'(DATA_W - 1);
            w_serial = w_piso_msb;
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          if (r_cnt != '0) begin
            w_cnt    = r_cnt - CNT_W'(1);
            w_serial = w_piso_next;
          end else begin
            w_state  = GAP;
            w_cnt    = CNT_W'(GAP_BITS - 1);
            w_serial = IDLE_LEVEL;
            w_done   = 1'b1;
          end
        end
      end
      GAP: begin
        if (bit_en) begin
          if (r_cnt != '0) begin
            w_cnt = r_cnt - CNT_W'(1);
          end else begin
            w_state = IDLE;
            w_ready = 1'b1;
          end
        end
      end
      default: begin
        w_state  = IDLE;
        w_serial = IDLE_LEVEL;
      end
    endcase
    w_active = (w_state == SYNC) || (w_state == DATA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_serial <= IDLE_LEVEL;
      r_ready  <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_serial <= w_serial;
      r_ready  <= w_ready;
      r_active <= w_active;
      r_done   <= w_done;
    end
  end

  assign data_ready   = r_ready;
  assign serial_out   = r_serial;
  assign frame_active = r_active;
  assign done         = r_done;

endmodule

// File: tb/tb_sync_pattern_transmitter.sv
// Self-checking bench: bit scoreboard fed at word hand-off, timing table per bit_en rate,
// plus held-valid, busy-ignore and mid-frame reset sequences.
module tb_sync_pattern_transmitter;

  typedef struct {
    logic [7:0] dat;
    int         period;
    int         exp_active;
    int         exp_done_at;
    int         exp_ready_at;
    int         exp_pulses;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_en;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_out;
  logic       frame_active;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int en_period = 1;
  int en_ctr = 0;
  bit mon_en = 1'b0;
  int active_cnt = 0;
  int done_cnt = 0;
  int done_at = 0;
  int pulse_cnt = 0;
  int acc_cyc = 0;
  int ready_at = 0;
  logic sb[$];
  vec_t vecs[4];

  sync_pattern_transmitter u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bit_en       (bit_en),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe generator: one bit_en every en_period cycles, none when en_period is 0.
  initial begin
    bit_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (en_period <= 0) begin
        bit_en = 1'b0;
      end else begin
        en_ctr++;
        if (en_ctr >= en_period) en_ctr = 0;
        bit_en = (en_ctr == 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // Every bit period ending while busy is scored against the queued frame.
  always @(negedge clk) begin
    if (frame_active) active_cnt++;
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
    if (mon_en && bit_en && !data_ready) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        timeout("serial_bit_unexpected");
      end else begin
        logic e;
        e = sb.pop_front();
        chk("serial_bit", int'(serial_out), int'(e));
      end
    end
  end

  task automatic push_frame(input logic [7:0] d);
    logic [3:0] sp;
    sp = 4'b1011;
    for (int i = 3; i >= 0; i--) sb.push_back(sp[i]);
    for (int i = 7; i >= 0; i--) sb.push_back(d[i]);
    sb.push_back(1'b0);
    sb.push_back(1'b0);
  endtask

  // Presents d for exactly one cycle, aligned with a bit_en strobe while ready.
  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!(data_ready && bit_en)) begin
      t++;
      if (t > 500) begin
        timeout("send_wait_ready");
        return;
      end
      @(negedge clk);
    end
    data_valid = 1'b1;
    data_in    = d;
    push_frame(d);
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    data_valid = 1'b0;
  endtask

  task automatic wait_ready(output int at);
    int t;
    t  = 0;
    at = -1;
    @(negedge clk);
    while (!data_ready) begin
      t++;
      if (t > 2000) begin
        timeout("wait_ready");
        return;
      end
      @(negedge clk);
    end
    at = cyc;
  endtask

  task automatic run_vec(input vec_t v);
    en_period = v.period;
    repeat (2) @(posedge clk);
    #2;
    active_cnt = 0;
    done_cnt   = 0;
    pulse_cnt  = 0;
    send(v.dat);
    wait_ready(ready_at);
    chk("frame_active_cycles", active_cnt, v.exp_active);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_at - acc_cyc, v.exp_done_at);
    chk("ready_latency", ready_at - acc_cyc, v.exp_ready_at);
    chk("bit_en_pulses", pulse_cnt, v.exp_pulses);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1, 12, 12, 14, 14};
    vecs[1] = '{8'hFF, 4, 48, 48, 56, 14};
    vecs[2] = '{8'h00, 3, 36, 36, 42, 14};
    vecs[3] = '{8'h5A, 2, 24, 24, 28, 14};

    reset_n    = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial_out", int'(serial_out), 0);
    chk("rst_data_ready", int'(data_ready), 0);
    chk("rst_frame_active", int'(frame_active), 0);
    chk("rst_done", int'(done), 0);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(data_ready), 1);
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Valid held high: second word taken on the edge right after data_ready rises.
    en_period = 1;
    repeat (2) @(posedge clk);
    #2;
    done_cnt   = 0;
    data_valid = 1'b1;
    data_in    = 8'h01;
    push_frame(8'h01);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    chk("held_first_accept", int'(data_ready), 0);
    data_in = 8'h80;
    push_frame(8'h80);
    wait_ready(ready_at);
    chk("held_ready_latency", ready_at - acc_cyc, 14);
    @(posedge clk);
    #1;
    chk("held_ready_one_cycle", int'(data_ready), 0);
    chk("held_second_active", int'(frame_active), 1);
    data_valid = 1'b0;
    wait_ready(ready_at);
    chk("held_done_count", done_cnt, 2);
    chk("held_scoreboard", sb.size(), 0);

    // A word offered mid-frame must be ignored and must not disturb the frame.
    en_period = 2;
    repeat (2) @(posedge clk);
    #2;
    done_cnt = 0;
    send(8'h5A);
    repeat (13) @(posedge clk);
    #2;
    data_valid = 1'b1;
    data_in    = 8'h3C;
    chk("busy_ready_low", int'(data_ready), 0);
    repeat (2) @(posedge clk);
    #2;
    chk("busy_ready_low_2", int'(data_ready), 0);
    data_valid = 1'b0;
    wait_ready(ready_at);
    chk("busy_done_count", done_cnt, 1);
    chk("busy_scoreboard", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("busy_no_late_frame", int'(frame_active), 0);
    chk("busy_ready_stays", int'(data_ready), 1);

    // Reset in the middle of the payload abandons the frame without done.
    en_period = 1;
    repeat (2) @(posedge clk);
    #2;
    done_cnt = 0;
    send(8'h96);
    repeat (7) @(posedge clk);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_serial_out", int'(serial_out), 0);
    chk("midrst_data_ready", int'(data_ready), 0);
    chk("midrst_frame_active", int'(frame_active), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2;
    chk("midrst_no_done", done_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_after_release", int'(data_ready), 1);
    mon_en   = 1'b1;
    done_cnt = 0;
    send(8'hC3);
    wait_ready(ready_at);
    chk("post_rst_ready_latency", ready_at - acc_cyc, 14);
    chk("post_rst_done_count", done_cnt, 1);
    chk("post_rst_scoreboard", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
